// File: rtl/pr_bridge_n.sv
// pr_bridge_n: CPU Pr* bus to N_DEV memory-mapped slots with wait-state stall and AdEL/AdES reporting.
// Optional macro PR_BRIDGE_TIMEOUT_EN adds the wait counter and the timeout-to-error path.
module pr_bridge_n #(
    parameter int          N_DEV     = 2,
    parameter logic [31:0] BASE      = 32'h0000_7F00,
    parameter int          WIN_BYTES = 16,
    parameter int          TIMEOUT   = 15,
    localparam int         AW        = ($clog2(WIN_BYTES) > 2) ? $clog2(WIN_BYTES) - 2 : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_be,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_stall,
    output logic [4:0]           exc_code,
    output logic [N_DEV-1:0]     dev_sel,
    output logic                 dev_we,
    output logic [AW-1:0]        dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [3:0]           dev_be,
    input  logic [N_DEV*32-1:0]  dev_rdata,
    input  logic [N_DEV-1:0]     dev_ack,
    input  logic [N_DEV-1:0]     dev_irq,
    output logic [5:0]           hw_int
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam int          SHIFT = $clog2(WIN_BYTES);
    localparam logic [31:0] SPAN  = 32'(N_DEV * WIN_BYTES);
    localparam logic [31:0] WMASK = 32'(WIN_BYTES - 1);

    state_t           state_q;
    logic             we_q;
    logic [N_DEV-1:0] devSel_q;
    logic             devWe_q;
    logic [AW-1:0]    devAddr_q;
    logic [31:0]      devWdata_q;
    logic [3:0]       devBe_q;
    logic [31:0]      cpuRdata_q;
    logic [4:0]       excCode_q;
    logic [5:0]       hwInt_q;
`ifdef PR_BRIDGE_TIMEOUT_EN
    logic [7:0]       waitCnt_q;
`endif

    logic [31:0]      offset_d;
    logic [31:0]      slotIdx_d;
    logic             hit_d;
    logic [AW-1:0]    wordOff_d;
    logic [N_DEV-1:0] decSel_d;
    logic             ackSel_d;
    logic [31:0]      ackData_d;

    // Unsigned subtraction makes addresses below BASE wrap high and miss the window.
    always_comb begin
        offset_d  = cpu_addr - BASE;
        hit_d     = offset_d < SPAN;
        slotIdx_d = offset_d >> SHIFT;
        wordOff_d = AW'((offset_d & WMASK) >> 2);
        decSel_d  = '0;
        for (int i = 0; i < N_DEV; i++) begin
            decSel_d[i] = (slotIdx_d == 32'(i));
        end
        ackSel_d  = |(dev_ack & devSel_q);
        ackData_d = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (devSel_q[i]) begin
                ackData_d = dev_rdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            devSel_q   <= '0;
            devWe_q    <= 1'b0;
            devAddr_q  <= '0;
            devWdata_q <= '0;
            devBe_q    <= '0;
            cpuRdata_q <= '0;
            excCode_q  <= '0;
            hwInt_q    <= '0;
`ifdef PR_BRIDGE_TIMEOUT_EN
            waitCnt_q  <= '0;
`endif
        end else begin
            hwInt_q <= 6'(dev_irq);
            case (state_q)
                IDLE: begin
                    excCode_q <= '0;
                    if (cpu_req) begin
                        we_q       <= cpu_we;
                        devAddr_q  <= wordOff_d;
                        devWdata_q <= cpu_wdata;
                        devBe_q    <= cpu_be;
                        if (hit_d) begin
                            state_q  <= ACCESS;
                            devSel_q <= decSel_d;
                            devWe_q  <= cpu_we;
`ifdef PR_BRIDGE_TIMEOUT_EN
                            waitCnt_q <= '0;
`endif
                        end else begin
                            state_q    <= ERR;
                            cpuRdata_q <= '0;
                            excCode_q  <= cpu_we ? 5'd5 : 5'd4;
                        end
                    end
                end
                ACCESS: begin
                    // Acks from slots other than the selected one are masked off in ackSel_d.
                    if (ackSel_d) begin
                        state_q    <= DONE;
                        cpuRdata_q <= we_q ? 32'd0 : ackData_d;
                        devSel_q   <= '0;
                        devWe_q    <= 1'b0;
                    end else begin
`ifdef PR_BRIDGE_TIMEOUT_EN
                        if (waitCnt_q == 8'(TIMEOUT)) begin
                            state_q    <= ERR;
                            cpuRdata_q <= '0;
                            excCode_q  <= we_q ? 5'd5 : 5'd4;
                            devSel_q   <= '0;
                            devWe_q    <= 1'b0;
                        end else begin
                            waitCnt_q <= waitCnt_q + 8'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    state_q   <= IDLE;
                    excCode_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_stall = cpu_req & (state_q != DONE) & (state_q != ERR);
    assign cpu_rdata = cpuRdata_q;
    assign exc_code  = excCode_q;
    assign dev_sel   = devSel_q;
    assign dev_we    = devWe_q;
    assign dev_addr  = devAddr_q;
    assign dev_wdata = devWdata_q;
    assign dev_be    = devBe_q;
    assign hw_int    = hwInt_q;

endmodule

// File: tb/tb_pr_bridge_n.sv
// tb_pr_bridge_n: directed self-checking bench for pr_bridge_n with N_DEV=2 and default window map.
// Covers decode, wait states, unmapped errors, timeout (PR_BRIDGE_TIMEOUT_EN) or unbounded wait, reset and irq path.
module tb_pr_bridge_n;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [4:0]  exc_code;
    logic [1:0]  dev_sel;
    logic        dev_we;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_be;
    logic [63:0] dev_rdata;
    logic [1:0]  dev_ack;
    logic [1:0]  dev_irq;
    logic [5:0]  hw_int;

    int checks = 0;
    int errors = 0;

    int         stalls;
    logic [1:0] selOr;
    logic       weAnd;
    logic [1:0] addrSeen;
    int         dataBad;

    pr_bridge_n #(
        .N_DEV(2),
        .BASE(32'h0000_7F00),
        .WIN_BYTES(16),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .exc_code(exc_code),
        .dev_sel(dev_sel),
        .dev_we(dev_we),
        .dev_addr(dev_addr),
        .dev_wdata(dev_wdata),
        .dev_be(dev_be),
        .dev_rdata(dev_rdata),
        .dev_ack(dev_ack),
        .dev_irq(dev_irq),
        .hw_int(hw_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Holds the request until stall drops, driving ackMask in cycle ackAt and noiseMask in cycle noiseAt.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [1:0] ackMask, input int ackAt,
                                 input logic [1:0] noiseMask, input int noiseAt, input int maxCycles);
        int c;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        stalls    = 0;
        selOr     = 2'b00;
        weAnd     = 1'b1;
        addrSeen  = 2'b00;
        dataBad   = 0;
        c         = 0;
        forever begin
            if (c == ackAt)        dev_ack = ackMask;
            else if (c == noiseAt) dev_ack = noiseMask;
            else                   dev_ack = 2'b00;
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            if (c >= 1) begin
                selOr = selOr | dev_sel;
                weAnd = weAnd & dev_we;
                if (c == 1) addrSeen = dev_addr;
                if (dev_wdata !== wdata || dev_be !== be) dataBad++;
            end
            c++;
            if (c >= maxCycles) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic endTxn();
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        dev_ack = 2'b00;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
        dev_rdata = '0;
        dev_ack   = '0;
        dev_irq   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_sel", 32'(dev_sel), 32'd0);
        checkOutput("rst_we", 32'(dev_we), 32'd0);
        checkOutput("rst_rdata", cpu_rdata, 32'd0);
        checkOutput("rst_exc", 32'(exc_code), 32'd0);
        checkOutput("rst_hwint", 32'(hw_int), 32'd0);
        checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] read slot1 zero-wait");
        dev_rdata = {32'hCAFE_F00D, 32'h1111_1111};
        applyStimulus(1'b0, 32'h0000_7F14, 32'd0, 4'hF, 2'b10, 1, 2'b00, -1, 20);
        checkOutput("rd1_stalls", 32'(stalls), 32'd2);
        checkOutput("rd1_sel", 32'(selOr), 32'd2);
        checkOutput("rd1_addr", 32'(addrSeen), 32'd1);
        checkOutput("rd1_rdata", cpu_rdata, 32'hCAFE_F00D);
        checkOutput("rd1_exc", 32'(exc_code), 32'd0);
        checkOutput("rd1_sel_done", 32'(dev_sel), 32'd0);
        endTxn();

        $display("[TB] unmapped read past last slot");
        applyStimulus(1'b0, 32'h0000_7F20, 32'd0, 4'hF, 2'b00, -1, 2'b00, -1, 20);
        checkOutput("unm_rd_stalls", 32'(stalls), 32'd1);
        checkOutput("unm_rd_sel", 32'(dev_sel), 32'd0);
        checkOutput("unm_rd_exc", 32'(exc_code), 32'd4);
        checkOutput("unm_rd_rdata", cpu_rdata, 32'd0);
        endTxn();
        @(negedge clk);
        checkOutput("unm_exc_clear", 32'(exc_code), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] write slot0 three wait cycles");
        dev_rdata = {32'hCAFE_F00D, 32'h1111_1111};
        applyStimulus(1'b1, 32'h0000_7F08, 32'h1234_5678, 4'b0011, 2'b01, 4, 2'b00, -1, 20);
        checkOutput("wr_stalls", 32'(stalls), 32'd5);
        checkOutput("wr_sel", 32'(selOr), 32'd1);
        checkOutput("wr_we", 32'(weAnd), 32'd1);
        checkOutput("wr_addr", 32'(addrSeen), 32'd2);
        checkOutput("wr_data_stable", 32'(dataBad), 32'd0);
        checkOutput("wr_rdata_zero", cpu_rdata, 32'd0);
        checkOutput("wr_exc", 32'(exc_code), 32'd0);
        endTxn();

        $display("[TB] unmapped write below base");
        applyStimulus(1'b1, 32'h0000_7EFC, 32'hFFFF_FFFF, 4'hF, 2'b00, -1, 2'b00, -1, 20);
        checkOutput("unm_wr_stalls", 32'(stalls), 32'd1);
        checkOutput("unm_wr_exc", 32'(exc_code), 32'd5);
        checkOutput("unm_wr_we", 32'(dev_we), 32'd0);
        endTxn();

        $display("[TB] read slot0 with stray ack from slot1");
        applyStimulus(1'b0, 32'h0000_7F04, 32'd0, 4'hF, 2'b01, 2, 2'b10, 1, 20);
        checkOutput("noise_stalls", 32'(stalls), 32'd3);
        checkOutput("noise_sel", 32'(selOr), 32'd1);
        checkOutput("noise_rdata", cpu_rdata, 32'h1111_1111);
        endTxn();

        $display("[TB] reset during access");
        dev_rdata = {32'hDEAD_BEEF, 32'h1111_1111};
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_7F14;
        cpu_wdata = 32'hA5A5_A5A5;
        cpu_be    = 4'hF;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rsta_sel_before", 32'(dev_sel), 32'd2);
        reset   = 1'b1;
        cpu_req = 1'b0;
        dev_ack = 2'b10;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        dev_ack = 2'b00;
        @(negedge clk);
        checkOutput("rsta_sel", 32'(dev_sel), 32'd0);
        checkOutput("rsta_addr", 32'(dev_addr), 32'd0);
        checkOutput("rsta_wdata", dev_wdata, 32'd0);
        checkOutput("rsta_be", 32'(dev_be), 32'd0);
        checkOutput("rsta_rdata", cpu_rdata, 32'd0);
        checkOutput("rsta_exc", 32'(exc_code), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0000_7F14, 32'd0, 4'hF, 2'b10, 1, 2'b00, -1, 20);
        checkOutput("rsta_new_stalls", 32'(stalls), 32'd2);
        checkOutput("rsta_new_rdata", cpu_rdata, 32'hDEAD_BEEF);
        endTxn();

        $display("[TB] interrupt path");
        dev_irq = 2'b01;
        @(negedge clk);
        checkOutput("irq_lat0", 32'(hw_int), 32'd0);
        @(posedge clk);
        #1;
        dev_irq = 2'b00;
        @(negedge clk);
        checkOutput("irq_set", 32'(hw_int), 32'h01);
        @(posedge clk);
        #1;
        dev_irq = 2'b10;
        @(negedge clk);
        checkOutput("irq_clear", 32'(hw_int), 32'h00);
        @(posedge clk);
        #1;
        dev_irq = 2'b00;
        @(negedge clk);
        checkOutput("irq_slot1", 32'(hw_int), 32'h02);
        @(posedge clk);
        #1;

`ifdef PR_BRIDGE_TIMEOUT_EN
        $display("[TB] read with no ack, timeout enabled");
        applyStimulus(1'b0, 32'h0000_7F00, 32'd0, 4'hF, 2'b00, -1, 2'b00, -1, 40);
        checkOutput("to_stalls", 32'(stalls), 32'd17);
        checkOutput("to_exc", 32'(exc_code), 32'd4);
        checkOutput("to_rdata", cpu_rdata, 32'd0);
        checkOutput("to_sel", 32'(dev_sel), 32'd0);
        endTxn();
`else
        $display("[TB] read with late ack, timeout disabled");
        applyStimulus(1'b0, 32'h0000_7F00, 32'd0, 4'hF, 2'b01, 120, 2'b00, -1, 200);
        checkOutput("nto_stalls", 32'(stalls), 32'd121);
        checkOutput("nto_exc", 32'(exc_code), 32'd0);
        checkOutput("nto_rdata", cpu_rdata, 32'h1111_1111);
        endTxn();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
